// File: rtl/dm_access_ctrl.sv
// ----------------------------------------------------------------------------
// dm_access_ctrl: byte/half/word load-store controller for a word-wide memory.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dm_access_ctrl #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_we_i,
  input  logic [1:0]    req_size_i,
  input  logic          req_signed_i,
  input  logic [31:0]   req_addr_i,
  input  logic [DW-1:0] req_wdata_i,
  output logic          resp_valid_o,
  input  logic          resp_ready_i,
  output logic [DW-1:0] resp_rdata_o,
  output logic          resp_err_o,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_wr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LD     = 3'd1,
    S_RMW_RD = 3'd2,
    S_WR     = 3'd3,
    S_RESP   = 3'd4
  } state_e;

  state_e        state_q;
  logic [1:0]    size_q;
  logic          signed_q;
  logic [1:0]    off_q;
  logic [15:0]   wdata_q;
  logic          req_ready_q;
  logic          resp_valid_q;
  logic [DW-1:0] resp_rdata_q;
  logic          resp_err_q;
  logic [AW-1:0] mem_addr_q;
  logic          mem_wr_q;
  logic [DW-1:0] mem_wdata_q;

  logic          req_err_d;
  logic [DW-1:0] lane_d;
  logic [DW-1:0] load_d;
  logic [DW-1:0] merge_d;

  always_comb begin
    req_err_d = (req_size_i == SZ_R)
              || ((req_size_i == SZ_H) && req_addr_i[0])
              || ((req_size_i == SZ_W) && (req_addr_i[1:0] != 2'b00))
              || (req_addr_i[31:AW+2] != '0);
  end

  // Shift the addressed lane down to bit 0, then extend to the full word.
  always_comb begin
    lane_d = mem_rdata_i >> {off_q, 3'b000};
    case (size_q)
      SZ_B:    load_d = {{24{signed_q & lane_d[7]}}, lane_d[7:0]};
      SZ_H:    load_d = {{16{signed_q & lane_d[15]}}, lane_d[15:0]};
      default: load_d = lane_d;
    endcase
  end

  always_comb begin
    merge_d = mem_rdata_i;
    if (size_q == SZ_B) begin
      merge_d[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merge_d[{off_q[1], 4'b0000} +: 16] = wdata_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      size_q       <= SZ_B;
      signed_q     <= 1'b0;
      off_q        <= 2'b00;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_wr_q     <= 1'b0;
      mem_wdata_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i && req_ready_q) begin
            req_ready_q <= 1'b0;
            size_q      <= req_size_i;
            signed_q    <= req_signed_i;
            off_q       <= req_addr_i[1:0];
            wdata_q     <= req_wdata_i[15:0];
            mem_addr_q  <= req_addr_i[AW+1:2];
            if (req_err_d) begin
              resp_err_q   <= 1'b1;
              resp_valid_q <= 1'b1;
              state_q      <= S_RESP;
            end else if (!req_we_i) begin
              state_q <= S_LD;
            end else if (req_size_i == SZ_W) begin
              mem_wdata_q <= req_wdata_i;
              mem_wr_q    <= 1'b1;
              state_q     <= S_WR;
            end else begin
              state_q <= S_RMW_RD;
            end
          end
        end
        S_LD: begin
          resp_rdata_q <= load_d;
          resp_valid_q <= 1'b1;
          state_q      <= S_RESP;
        end
        S_RMW_RD: begin
          mem_wdata_q <= merge_d;
          mem_wr_q    <= 1'b1;
          state_q     <= S_WR;
        end
        S_WR: begin
          mem_wr_q     <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wr_o     = mem_wr_q;
  assign mem_wdata_o  = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dm_access_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dm_access_ctrl: randomized scoreboard bench against a byte-array memory model.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dm_access_ctrl;

  localparam int AW = 10;
  localparam int NW = 1 << AW;
  localparam int NB = NW * 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] mem_addr;
  logic          mem_wr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  always #5 clk = ~clk;

  dm_access_ctrl #(.AW(AW), .DW(32)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_size_i   (req_size),
    .req_signed_i (req_signed),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_rdata_o (resp_rdata),
    .resp_err_o   (resp_err),
    .mem_addr_o   (mem_addr),
    .mem_wr_o     (mem_wr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata)
  );

  // Physical memory seen by the DUT: combinational read, falling-edge write.
  logic [31:0] mem [0:NW-1];
  assign mem_rdata = mem[mem_addr];
  always @(negedge clk) if (mem_wr) mem[mem_addr] <= mem_wdata;

  logic [7:0] ref_mem [0:NB-1];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nwr;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   wr_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
  endfunction

  task automatic reset_vals(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wr"}, 32'(mem_wr), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  // Monitor: pops an expectation on each new response and checks it stays stable.
  initial begin : monitor
    logic        prev_v;
    logic [31:0] hold_rd;
    logic        hold_err;
    exp_t        e;
    prev_v = 1'b0;
    hold_rd = '0;
    hold_err = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        prev_v = 1'b0;
        wr_cnt = 0;
        continue;
      end
      if (mem_wr) wr_cnt++;
      if (resp_valid) begin
        chk("resp_req_ready_low", 32'(req_ready), 32'd0);
        chk("resp_no_mem_wr", 32'(mem_wr), 32'd0);
        if (!prev_v) begin
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_resp: got rdata %h err %0d with nothing outstanding", resp_rdata, resp_err);
          end else begin
            e = sb.pop_front();
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_err", 32'(resp_err), 32'(e.err));
            chk("resp_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            chk("mem_wr_pulses", 32'(wr_cnt), 32'(e.nwr));
            wr_cnt = 0;
          end
          hold_rd = resp_rdata;
          hold_err = resp_err;
        end else begin
          chk("resp_rdata_stable", resp_rdata, hold_rd);
          chk("resp_err_stable", 32'(resp_err), 32'(hold_err));
        end
      end
      prev_v = resp_valid;
    end
  end

  task automatic do_req(input logic we, input logic [1:0] sz, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wd, input int stall);
    exp_t        e;
    int          n;
    int          nb;
    logic [31:0] v;
    nb = 1 << sz;
    e.err = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00)
            || (addr >= 32'(NB));
    e.rdata = '0;
    e.nwr = 0;
    if (e.err) e.lat = 1;
    else if (!we) e.lat = 2;
    else if (sz == 2'b10) e.lat = 2;
    else e.lat = 3;
    if (!e.err && !we) begin
      v = '0;
      for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[addr + 32'(i)]) << (8 * i));
      if (sgn && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
      e.rdata = v;
    end
    if (!e.err && we) e.nwr = 1;

    @(negedge clk);
    n = 0;
    while (!req_ready && n < 10) begin @(negedge clk); n++; end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we = we;
    req_size = sz;
    req_signed = sgn;
    req_addr = addr;
    req_wdata = wd;
    resp_ready = (stall == 0);
    e.acc = cyc + 1;
    sb.push_back(e);
    if (!e.err && we)
      for (int i = 0; i < nb; i++) ref_mem[addr + 32'(i)] = 8'(wd >> (8 * i));
    @(posedge clk); #2;
    req_valid = 1'b0;
    req_we = 1'($urandom);
    req_size = 2'($urandom);
    req_addr = $urandom;
    req_wdata = $urandom;

    n = 0;
    while (!resp_valid && n < 8) begin @(posedge clk); #2; n++; end
    if (!resp_valid) begin
      errors++;
      $display("FAIL resp_timeout: got no resp_valid after %0d cycles, required within %0d", n, e.lat);
    end
    repeat (stall) @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #2;
    chk("hs_resp_valid_clr", 32'(resp_valid), 32'd0);
    chk("hs_req_ready_set", 32'(req_ready), 32'd1);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int          r;
    logic [1:0]  sz;
    logic [31:0] a;
    int          bad;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_size = 2'b00;
    req_signed = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < NW; i++) mem[i] = '0;
    for (int i = 0; i < NB; i++) ref_mem[i] = '0;

    repeat (3) @(posedge clk);
    #1 reset_vals("rst");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 reset_vals("post_rst");

    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h8899AABB, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0);
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0);
    do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 0);
    do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 0);
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h12345655, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
    do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000CAFE, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
    do_req(1'b0, 2'b01, 1'b1, 32'h11, 32'h0, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h1E, 32'h0, 0);
    do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 0);
    do_req(1'b1, 2'b10, 1'b0, 32'h00001000, 32'h11223344, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);

    // Reset lands inside the WR cycle, before its falling edge.
    @(negedge clk);
    req_valid = 1'b1;
    req_we = 1'b1;
    req_size = 2'b10;
    req_signed = 1'b0;
    req_addr = 32'h20;
    req_wdata = 32'hDEADBEEF;
    @(posedge clk); #2;
    req_valid = 1'b0;
    chk("abort_in_wr", 32'(mem_wr), 32'd1);
    rst_n = 1'b0;
    #1 reset_vals("abort");
    @(negedge clk); #1;
    chk("abort_word_0x20", mem[8], ref_word(8));
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2 chk("abort_no_resp", 32'(resp_valid), 32'd0);

    for (int k = 0; k < 200; k++) begin
      r = $urandom_range(0, 99);
      sz = (r < 8) ? 2'b11 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 99) < 6) a = $urandom | 32'h0000_1000;
      else a = 32'($urandom_range(0, 127));
      if (sz != 2'b11 && $urandom_range(0, 99) < 75) a = a & ~((32'd1 << sz) - 32'd1);
      do_req(1'($urandom), sz, 1'($urandom), a, $urandom,
             ($urandom_range(0, 99) < 20) ? $urandom_range(1, 3) : 0);
    end

    repeat (4) @(posedge clk);
    #3 chk("sb_empty", 32'(sb.size()), 32'd0);
    bad = 0;
    for (int w = 0; w < NW; w++) if (mem[w] !== ref_word(w)) bad++;
    chk("mem_image_mismatched_words", 32'(bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- Initiator-side controller for the word-organised data memory.
- Accepts byte, halfword and word load/store requests from the CPU datapath over a valid/ready handshake.
- Drives the memory's word address, write strobe and write data; performs read-modify-write for sub-word stores.
- Returns sign- or zero-extended load data, or an error, over a valid/ready response channel.

Parameters:
- AW, 10, word-address width of the memory; the memory holds 2^AW words and the byte address space is 2^(AW+2).
- DW, 32, data width (fixed at 32; the parameter exists only for documentation and lint).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
- req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts response.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned, out-of-range or reserved-size request.
- mem_addr  output  AW  word address to memory (byte address [AW+1:2]).
- mem_wr  output  1  memory write strobe; the memory commits on the falling edge of clk.
- mem_wdata  output  32  word written to memory.
- mem_rdata  input  32  combinational read data for mem_addr.

Behaviour:
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_addr=0, mem_wr=0, mem_wdata=0.
- All outputs are registered.
- A request is accepted on a rising edge where req_valid & req_ready.
  - All request fields are latched at acceptance.
  - req_ready is 1 only in IDLE.
- Byte lanes are little-endian: byte offset 0 is bits [7:0], offset 3 is bits [31:24].
- Error check at acceptance. Any of the following sets resp_err=1:
  - size 11;
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0;
  - any addr[31:AW+2] != 0.
- Error path:
  - Goes directly to RESP with resp_rdata=0.
  - No memory access; mem_wr is never asserted.
- States:
  - IDLE: wait for a request. On acceptance, register mem_addr, then:
    - error -> RESP
    - load -> LD
    - word store -> WR, with mem_wdata=req_wdata
    - sub-word store -> RMW_RD
  - LD (1 cycle): at the end of the cycle, capture mem_rdata, select the lane, extend per size/signed into resp_rdata -> RESP. Load latency is 2 edges from acceptance to resp_valid.
  - RMW_RD (1 cycle): at the end of the cycle, merge req_wdata's low byte or halfword into the captured mem_rdata at the addressed lane; register the merged word as mem_wdata, set mem_wr=1 -> WR.
  - WR (1 cycle): mem_wr=1 for exactly this cycle (the falling edge inside it commits); deassert on exit -> RESP.
  - RESP: resp_valid=1 with stable resp_rdata/resp_err until resp_ready is seen on a rising edge. Then resp_valid=0 and all response fields cleared -> IDLE.
- Cycle counts, acceptance to first resp_valid edge:
  - load: 2
  - word store: 2
  - sub-word store: 3
  - error: 1
- mem_wr is asserted exactly once per successful store, never for loads or errors.
- Other words are never written; lanes of the addressed word not targeted by the store retain their prior values.
- Back-to-back: a new request can be accepted at the earliest on the edge after the response handshake completes (one IDLE cycle minimum). No pipelining; one outstanding request.
- Response handshake:
  - resp_ready held high in RESP -> transaction completes on the first edge.
  - resp_ready low -> stall indefinitely, with no memory activity during the stall.
- Asynchronous reset mid-operation returns to IDLE with all outputs at reset values immediately.
  - mem_wr drops immediately, so a write in WR aborted before the falling edge must not commit.
  - The in-flight request is discarded; no response is issued.
- Inputs other than req_valid are don't-care while req_valid=0 or req_ready=0.

Test Plan:
- Reset with memory zeroed; sw addr 0x10 data 0x8899AABB; then lw 0x10 -> one mem_wr pulse at mem_addr 4; load response 0x8899AABB, err 0, response 2 cycles after acceptance.
- From the word above: lb signed at 0x13 -> 0xFFFFFF88; lbu at 0x13 -> 0x00000088; lh signed at 0x10 -> 0xFFFFAABB; lhu at 0x12 -> 0x00008899.
- sb 0x11 data 0x12345655, then lw 0x10 -> 0x889955BB. sh 0x12 data 0x0000CAFE, then lw 0x10 -> 0xCAFE55BB. Each partial store takes 3 cycles to response with a single mem_wr pulse.
- Errors: lh 0x11, lw 0x1E, size 11, and sw to 0x00001000 with AW=10 -> each gives resp_err=1 and resp_rdata=0, 1 cycle to response, mem_wr never asserted, memory contents unchanged.
- Hold resp_ready=0 for 5 cycles after lw -> resp_valid and data stable, req_ready=0, no mem_wr. Raising resp_ready completes the transaction; the next request is accepted after one IDLE cycle.
- Assert rst_n=0 during WR of sw 0x20 data 0xDEADBEEF before the falling edge -> mem_wr drops immediately, word at 0x20 remains 0, outputs at reset values, no response issued.
